// File: rtl/types_pkg.sv
// types_pkg: shared rename/RS payload types and core-wide constants
package types_pkg;
  localparam int NUM_PREG = 128;
  localparam int PREG_W = $clog2(NUM_PREG);
  localparam int FU_ALU = 0;
  localparam int FU_LSU = 1;
  localparam int FU_BR = 2;
  typedef struct packed {
    logic [5:0] op;
    logic [PREG_W-1:0] ps1;
    logic [PREG_W-1:0] ps2;
    logic [PREG_W-1:0] pd_new;
    logic [1:0] fu;
  } rename_data;
  typedef struct packed {
    rename_data d;
    logic ps1_rdy;
    logic ps2_rdy;
    logic [4:0] rob_idx;
  } rs_data;
endpackage

// File: rtl/preg_ready_table.sv
// preg_ready_table: physical-register ready bits with clear-over-set priority and CDB forwarding
module preg_ready_table import types_pkg::*; #(
  parameter int N = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic [PREG_W-1:0] i_clr_idx,
  input  logic              i_set,
  input  logic [PREG_W-1:0] i_set_idx,
  output logic [N-1:0]      o_rtable
);
  logic [N-1:0] r_table;
  logic [N-1:0] w_fwd;
  // the later clear overrides a same-index set; preg 0 is never cleared
  always_ff @(posedge clk)
    if (!reset) r_table <= '1;
    else begin
      if (i_set) r_table[i_set_idx] <= 1'b1;
      if (i_clr && i_clr_idx != '0) r_table[i_clr_idx] <= 1'b0;
    end
  assign w_fwd = i_set ? N'(1) << i_set_idx : '0;
  assign o_rtable = r_table | w_fwd;
endmodule

// File: rtl/dispatch_unit.sv
// dispatch_unit: single-entry hold between rename and the reservation stations, with ROB allocation
module dispatch_unit import types_pkg::*; #(
  parameter int NUM_PREG = 128,
  parameter int NUM_RS = 3,
  parameter int ROB_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  rename_data           r_data,
  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic                 rob_full,
  input  logic [ROB_IDX_W-1:0] rob_index,
  output logic                 rob_alloc,
  input  logic [NUM_RS-1:0]    rs_full,
  output logic [NUM_RS-1:0]    di_en,
  output rename_data           d_data,
  output logic [ROB_IDX_W-1:0] rob_index_out,
  input  logic [PREG_W-1:0]    ps_in,
  input  logic                 ps_ready,
  input  logic                 mispredict,
  output logic [NUM_PREG-1:0]  preg_rtable,
  output logic                 err
);
  logic             r_valid_q;
  rename_data       r_data_q;
  logic             r_err;
  logic [NUM_RS-1:0] w_sel;
  logic             w_fire;
  logic             w_bad;
  logic             w_acc;
  assign w_sel = NUM_RS'(1) << r_data_q.fu;
  assign w_bad = r_valid_q && r_data_q.fu == 2'd3;
  // reset gates fire so an entry held when reset drops never strobes
  assign w_fire = reset && r_valid_q && 32'(r_data_q.fu) < NUM_RS && !rob_full
                  && !(|(rs_full & w_sel)) && !mispredict;
  assign r_ready = reset && !mispredict && (!r_valid_q || w_fire || w_bad);
  assign w_acc = r_valid && r_ready;
  assign di_en = w_fire ? w_sel : '0;
  assign rob_alloc = w_fire;
  assign rob_index_out = w_fire ? rob_index : '0;
  assign d_data = r_data_q;
  assign err = r_err;
  always_ff @(posedge clk)
    if (!reset) begin
      r_valid_q <= 1'b0;
      r_data_q <= '0;
      r_err <= 1'b0;
    end else begin
      r_valid_q <= w_acc || (r_valid_q && !w_fire && !w_bad && !mispredict);
      if (w_acc) r_data_q <= r_data;
      if (w_bad) r_err <= 1'b1;
    end
  preg_ready_table #(.N(NUM_PREG)) u_table (
    .clk(clk),
    .reset(reset),
    .i_clr(w_fire),
    .i_clr_idx(r_data_q.pd_new),
    .i_set(ps_ready),
    .i_set_idx(ps_in),
    .o_rtable(preg_rtable)
  );
endmodule

// File: tb/tb_dispatch_unit.sv
// tb_dispatch_unit: directed and random stimulus checked each cycle against a behavioural model
module tb_dispatch_unit;
  import types_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, r_valid, r_ready, rob_full, rob_alloc, ps_ready, mispredict, err;
  rename_data r_data, d_data;
  logic [4:0] rob_index, rob_index_out;
  logic [2:0] rs_full, di_en;
  logic [6:0] ps_in;
  logic [127:0] preg_rtable;
  int n_tests = 0, n_fail = 0;
  bit m_valid, m_err;
  rename_data m_data;
  bit m_table[128];
  dispatch_unit dut (
    .clk(clk), .reset(reset), .r_data(r_data), .r_valid(r_valid), .r_ready(r_ready),
    .rob_full(rob_full), .rob_index(rob_index), .rob_alloc(rob_alloc), .rs_full(rs_full),
    .di_en(di_en), .d_data(d_data), .rob_index_out(rob_index_out), .ps_in(ps_in),
    .ps_ready(ps_ready), .mispredict(mispredict), .preg_rtable(preg_rtable), .err(err)
  );
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic rename_data mk(input logic [1:0] fu, input logic [6:0] pd);
    rename_data d;
    d = '0;
    d.fu = fu;
    d.pd_new = pd;
    d.ps1 = 7'(pd + 7'd1);
    d.op = 6'h2a;
    return d;
  endfunction
  function automatic bit mfire();
    return reset && !mispredict && m_valid && m_data.fu != 2'd3 && !rob_full && !rs_full[m_data.fu];
  endfunction
  function automatic bit mready();
    return reset && !mispredict && (!m_valid || mfire() || m_data.fu == 2'd3);
  endfunction
  task automatic look();
    bit f;
    logic [127:0] ep;
    @(negedge clk);
    f = mfire();
    for (int i = 0; i < 128; i++) ep[i] = m_table[i] | (ps_ready && int'(ps_in) == i);
    chk("di_en", di_en, f ? 3'b001 << m_data.fu : 3'b000);
    chk("rob_alloc", rob_alloc, f);
    if (f) chk("rob_index_out", rob_index_out, rob_index);
    chk("r_ready", r_ready, mready());
    chk("d_data", d_data, m_data);
    chk("preg_rtable", preg_rtable, ep);
    chk("err", err, m_err);
  endtask
  task automatic tick();
    bit f, acc, bad;
    f = mfire();
    acc = r_valid && mready();
    bad = m_valid && m_data.fu == 2'd3;
    if (!reset) begin
      m_valid = 0;
      m_data = '0;
      m_err = 0;
      foreach (m_table[i]) m_table[i] = 1;
    end else begin
      if (ps_ready) m_table[ps_in] = 1;
      if (f && m_data.pd_new != 0) m_table[m_data.pd_new] = 0;
      if (bad) m_err = 1;
      if (acc) begin
        m_valid = 1;
        m_data = r_data;
      end else if (f || mispredict || bad) m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic cyc();
    look();
    tick();
  endtask
  task automatic idle();
    reset = 1; r_valid = 0; r_data = '0; rob_full = 0; rob_index = 0;
    rs_full = 0; ps_in = 0; ps_ready = 0; mispredict = 0;
  endtask
  initial begin
    logic [31:0] tmp;
    idle();
    reset = 0;
    m_valid = 0; m_err = 0; m_data = '0;
    foreach (m_table[i]) m_table[i] = 1;
    @(posedge clk); #1;
    cyc();
    look();
    chk("rst_r_ready", r_ready, 1'b0);
    chk("rst_di_en", di_en, 3'b000);
    chk("rst_table", preg_rtable, {128{1'b1}});
    chk("rst_err", err, 1'b0);
    tick();
    reset = 1;
    look();
    chk("post_rst_ready", r_ready, 1'b1);
    r_valid = 1; r_data = mk(2'd0, 7'd20); rob_index = 5'd3;
    tick();
    r_valid = 0;
    look();
    chk("t1_di_en", di_en, 3'b001);
    chk("t1_alloc", rob_alloc, 1'b1);
    chk("t1_rob_idx", rob_index_out, 5'd3);
    tick();
    look();
    chk("t1_preg20", preg_rtable[20], 1'b0);
    r_valid = 1; r_data = mk(2'd1, 7'd30);
    tick();
    r_valid = 0; rs_full = 3'b010;
    for (int k = 0; k < 4; k++) begin
      look();
      chk("stall_di_en", di_en, 3'b000);
      chk("stall_ready", r_ready, 1'b0);
      chk("stall_pd", d_data.pd_new, 7'd30);
      tick();
    end
    rs_full = 3'b000;
    look();
    chk("release_di_en", di_en, 3'b010);
    tick();
    r_valid = 1; r_data = mk(2'd0, 7'd13);
    cyc();
    r_valid = 0;
    cyc();
    ps_ready = 1; ps_in = 7'd13;
    look();
    chk("fwd13", preg_rtable[13], 1'b1);
    tick();
    ps_ready = 0;
    look();
    chk("set13", preg_rtable[13], 1'b1);
    tick();
    r_valid = 1; r_data = mk(2'd2, 7'd25);
    cyc();
    r_valid = 0; ps_ready = 1; ps_in = 7'd25;
    look();
    chk("t25_di_en", di_en, 3'b100);
    tick();
    ps_ready = 0;
    look();
    chk("clr_wins25", preg_rtable[25], 1'b0);
    tick();
    r_valid = 1; r_data = mk(2'd0, 7'd0);
    cyc();
    r_valid = 0; ps_ready = 1; ps_in = 7'd0;
    cyc();
    ps_ready = 0;
    look();
    chk("preg0", preg_rtable[0], 1'b1);
    tick();
    rob_full = 1; r_valid = 1; r_data = mk(2'd0, 7'd40);
    cyc();
    r_valid = 0;
    look();
    chk("robfull_alloc", rob_alloc, 1'b0);
    tick();
    mispredict = 1;
    look();
    chk("mis_di_en", di_en, 3'b000);
    chk("mis_ready", r_ready, 1'b0);
    tick();
    mispredict = 0; rob_full = 0;
    look();
    chk("post_mis_di_en", di_en, 3'b000);
    chk("post_mis_ready", r_ready, 1'b1);
    tick();
    r_valid = 1; r_data = mk(2'd3, 7'd44);
    cyc();
    r_valid = 0;
    look();
    chk("bad_di_en", di_en, 3'b000);
    chk("bad_alloc", rob_alloc, 1'b0);
    tick();
    look();
    chk("err_set", err, 1'b1);
    r_valid = 1; r_data = mk(2'd2, 7'd50);
    tick();
    r_valid = 0;
    look();
    chk("after_bad_di_en", di_en, 3'b100);
    tick();
    look();
    chk("err_sticky", err, 1'b1);
    tick();
    r_valid = 1; r_data = mk(2'd1, 7'd60); rs_full = 3'b010;
    cyc();
    r_valid = 0; reset = 0;
    look();
    chk("rst_stall_di_en", di_en, 3'b000);
    tick();
    reset = 1; rs_full = 0;
    look();
    chk("rst_stall_lost", di_en, 3'b000);
    chk("rst_err_clr", err, 1'b0);
    tick();
    for (int k = 0; k < 3000; k++) begin
      reset = $urandom_range(63) != 0;
      r_valid = $urandom_range(3) != 0;
      tmp = $urandom;
      r_data = tmp[$bits(rename_data)-1:0];
      if (r_data.fu == 2'd3 && $urandom_range(3) != 0) r_data.fu = 2'($urandom_range(2));
      r_data.pd_new = 7'($urandom_range(31));
      rob_full = $urandom_range(3) == 0;
      rs_full = $urandom_range(1) != 0 ? 3'($urandom) : 3'b000;
      rob_index = 5'($urandom);
      ps_ready = $urandom_range(1) != 0;
      ps_in = 7'($urandom_range(31));
      mispredict = $urandom_range(15) == 0;
      cyc();
    end
    idle();
    reset = 0;
    cyc();
    reset = 1;
    look();
    chk("final_err", err, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dispatch_unit.md
# dispatch_unit

Single-entry dispatch stage between rename and the reservation stations of the out-of-order core. It latches one rename_data per cycle from rename and allocates a ROB entry for it. It then steers the instruction to the reservation station selected by its fu field, stalling when either side is full. It also owns the physical-register ready table (preg_rtable) that every reservation station samples at dispatch: it clears bits on allocation, sets them on CDB broadcast and forwards the broadcast in the same cycle.

## Interface
- NUM_PREG, default 128, number of physical registers; ready-table depth.
- NUM_RS, default 3, number of reservation stations (fu 0 = ALU, 1 = LSU, 2 = branch).
- ROB_IDX_W, default 5, ROB tag width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- r_data  in  rename_data  renamed instruction from rename.
- r_valid  in  1  r_data valid.
- r_ready  out  1  dispatch can accept r_data this cycle.
- rob_full  in  1  ROB cannot allocate.
- rob_index  in  ROB_IDX_W  tag the ROB will assign to the next allocation.
- rob_alloc  out  1  ROB allocation strobe.
- rs_full  in  NUM_RS  per-station full flags.
- di_en  out  NUM_RS  one-hot write strobe to the selected station.
- d_data  out  rename_data  held instruction, broadcast to all stations.
- rob_index_out  out  ROB_IDX_W  rob_index passed through when rob_alloc is high.
- ps_in  in  7  CDB physical register tag.
- ps_ready  in  1  CDB broadcast valid.
- mispredict  in  1  flush.
- preg_rtable  out  NUM_PREG  operand-ready bits, with CDB forwarding.
- err  out  1  sticky flag: an illegal fu value was received.

## Operation
- State:
  - hold register: valid_q, data_q.
  - table_q[NUM_PREG].
  - err_q.
- fire = valid_q && fu_q < NUM_RS && !rob_full && !rs_full[fu_q] && !mispredict.
- On fire, all in the same cycle:
  - di_en[fu_q] = 1 (all other bits 0).
  - rob_alloc = 1.
  - rob_index_out = rob_index.
  - table_q[pd_new] cleared at the edge, unless pd_new == 0. Physical register 0 is always ready.
- r_ready = reset && !mispredict && (!valid_q || fire || fu_q == 3).
- Accept occurs when r_valid && r_ready; data_q is loaded at the edge.
- Hold register next state: set on accept; cleared on fire without accept; unchanged otherwise.
- Illegal fu == 3:
  - The entry is discarded on the next edge.
  - No di_en and no rob_alloc are asserted.
  - err_q is set and stays set until reset.
- CDB: when ps_ready, table_q[ps_in] is set at the edge.
- Simultaneous clear (fire with pd_new == X) and set (CDB with ps_in == X): the clear wins.
- Forwarding: preg_rtable[i] = table_q[i] | (ps_ready && ps_in == i). This lets a station sampling at dispatch see a same-cycle wakeup.
- Mispredict:
  - valid_q is cleared at the edge and any input is refused that cycle.
  - No di_en is issued.
  - table_q is unchanged; stale clears are resolved by later CDB or re-allocation.
- Stalls hold data_q stable. d_data equals data_q at all times.

## Timing
- Reset values (after reset low at an edge):
  - valid_q = 0 and err = 0.
  - table_q all 1.
  - r_ready = 0 while reset is low, 1 on the first cycle after.
  - di_en = 0, rob_alloc = 0.
- Latency: accepted at edge N; di_en and rob_alloc are high in cycle N+1 if there are no stalls.
- Throughput: one instruction per cycle; back-to-back accept and fire in the same cycle is allowed.
- rob_full and rs_full are combinational inputs to fire. A station full in cycle N blocks dispatch that cycle only.
- Reset mid-stall: the held instruction is lost and no strobe is issued.
- mispredict and fire never coexist; mispredict has priority.

## Structure
- rename_data and rs_data live in types_pkg, extended with localparams FU_ALU=0, FU_LSU=1, FU_BR=2 and NUM_PREG.
- One natural sub-module, preg_ready_table:
  - contains table_q, the clear/set priority and the forwarding OR.
  - the hold register and handshake stay in dispatch_unit.

## Test plan
- Reset, then r_valid with fu=0, pd_new=20, rob_index=3 → one cycle later:
  - di_en=3'b001 and rob_alloc=1;
  - rob_index_out=3;
  - preg_rtable[20]=0 on the following cycle.
- Hold with fu=1 and rs_full=3'b010 for 4 cycles → di_en stays 0 and r_ready=0; d_data stays stable. When rs_full is released: di_en=3'b010 in that cycle.
- ps_ready=1 with ps_in=13 in the same cycle table_q[13]=0 → preg_rtable[13]=1 that cycle; table_q[13]=1 after the edge.
- Fire with pd_new=25 while the CDB carries ps_in=25 → preg_rtable[25]=0 after the edge. Repeat with pd_new=0: preg_rtable[0] stays 1.
- Entry held with rob_full=1, then mispredict=1 → no di_en ever issued; valid_q=0; r_ready=1 the cycle after.
- r_data.fu=3 → no di_en and no rob_alloc; err=1 from the next cycle and sticky until reset. A following fu=2 instruction dispatches normally.
